// File: rtl/booth_seq_divider_pkg.sv
// Shared types and default widths for the sequential signed divider.
package booth_seq_divider_pkg;

  // Default widths: dividend/quotient match the multiplier product,
  // divisor/remainder match the multiplier operand.
  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

  // Iteration counter must hold the value DIVIDEND_W itself.
  localparam int CNT_W = $clog2(DIVIDEND_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/booth_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor magnitude, keep the difference or restore.
module booth_div_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   prem_in,
  input  logic                 dvd_bit,
  input  logic [DIVISOR_W-1:0] dvs_mag,
  output logic [DIVISOR_W:0]   prem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] diff;

  // Trial subtract is one bit wider than the shifted remainder so its MSB
  // is a clean borrow (negative-result) indicator.
  always_comb begin
    shifted = {prem_in, dvd_bit};
    diff    = shifted - {2'b00, dvs_mag};
    q_bit   = ~diff[DIVISOR_W+1];
    // Whichever value is kept is below |divisor|, so it fits the narrower register.
    prem_out = q_bit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/booth_seq_divider.sv
// Multi-cycle signed divider: restoring division on magnitudes, one quotient
// bit per cycle, sign fix-up in a final cycle, valid/ready on both sides.
module booth_seq_divider
  import booth_seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  // Counter is never narrower than the package default, and grows if the
  // dividend width is overridden upward.
  localparam int CW = (CNT_W > $clog2(DIVIDEND_W + 1)) ? CNT_W : $clog2(DIVIDEND_W + 1);

  state_e                state, state_nxt;
  logic [CW-1:0]         count;
  logic [DIVIDEND_W-1:0] work;      // dividend bits shift out, quotient bits shift in
  logic [DIVISOR_W:0]    prem;
  logic [DIVISOR_W-1:0]  dvs_mag;
  logic                  neg_q;
  logic                  neg_r;
  logic                  ovf_case;

  logic                  accept;
  logic                  dvs_zero;
  logic                  last_step;
  logic [DIVIDEND_W-1:0] dvd_mag_in;
  logic [DIVISOR_W-1:0]  dvs_mag_in;
  logic                  ovf_in;
  logic [DIVISOR_W:0]    prem_nxt;
  logic                  q_bit;
  logic [DIVISOR_W-1:0]  rem_mag;

  booth_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .prem_in  (prem),
    .dvd_bit  (work[DIVIDEND_W-1]),
    .dvs_mag  (dvs_mag),
    .prem_out (prem_nxt),
    .q_bit    (q_bit)
  );

  // Operand decode: magnitudes are unsigned, so the most negative value maps
  // to its true magnitude (e.g. -8 -> 8 in four bits).
  always_comb begin
    accept     = in_valid && in_ready;
    dvs_zero   = (divisor == '0);
    dvd_mag_in = dividend[DIVIDEND_W-1] ? -dividend : dividend;
    dvs_mag_in = divisor[DIVISOR_W-1]   ? -divisor  : divisor;
    ovf_in     = (dividend == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (divisor == '1);
    last_step  = (count == CW'(1));
    rem_mag    = prem[DIVISOR_W-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front;
    // a path that leaves one unassigned infers a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = dvs_zero ? DONE : CALC;
      end
      CALC: if (last_step) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      count       <= '0;
      work        <= '0;
      prem        <= '0;
      dvs_mag     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      ovf_case    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            count       <= CW'(DIVIDEND_W);
            work        <= dvd_mag_in;
            prem        <= '0;
            dvs_mag     <= dvs_mag_in;
            neg_q       <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            neg_r       <= dividend[DIVIDEND_W-1];
            ovf_case    <= ovf_in;
            div_by_zero <= dvs_zero;
            overflow    <= 1'b0;
            if (dvs_zero) begin
              quotient  <= '1;
              remainder <= '0;
            end
          end
        end
        CALC: begin
          prem  <= prem_nxt;
          work  <= {work[DIVIDEND_W-2:0], q_bit};
          count <= count - CW'(1);
        end
        FIX: begin
          // A magnitude of 2^(W-1) with matching signs wraps to the most
          // negative value, which is exactly the overflow result.
          quotient  <= neg_q ? -work : work;
          remainder <= neg_r ? -rem_mag : rem_mag;
          overflow  <= ovf_case;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_divider.sv
// Self-checking bench for booth_seq_divider: directed corner cases,
// backpressure, mid-operation reset and a full operand sweep in random order.
module tb_booth_seq_divider;

  localparam int DW = 8;
  localparam int VW = 4;
  localparam int NORMAL_LAT = DW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;

  booth_seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division truncates toward zero and the
  // remainder takes the dividend's sign; results are reduced to port width.
  function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                output logic [DW-1:0] q, output logic [VW-1:0] r,
                                output logic dz, output logic ov);
    int ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (bi == 0) begin
      q  = '1;
      r  = '0;
      dz = 1'b1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      ov = (qi > 127);
      q  = qi[DW-1:0];
      r  = ri[VW-1:0];
    end
  endfunction

  // Issue one operation, wait for the result, hold it for 'hold' cycles,
  // then accept it and confirm the handshake completes once.
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input int hold, input string tag);
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          edz, eov;
    int            lat;
    model(a, b, eq, er, edz, eov);
    @(negedge clk);
    check({tag, " in_ready_idle"}, in_ready, 1'b1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        // Operands must be ignored once the divider is busy.
        in_valid = 1'b1;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
      end
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    check({tag, " latency"}, lat, (b == '0) ? 1 : NORMAL_LAT);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " div_by_zero"}, div_by_zero, edz);
      check({tag, " overflow"}, overflow, eov);
      if (hold > 0) begin
        check({tag, " hold_valid"}, out_valid, 1'b1);
        check({tag, " hold_in_ready"}, in_ready, 1'b0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid_drop"}, out_valid, 1'b0);
    check({tag, " in_ready_rise"}, in_ready, 1'b1);
  endtask

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
  } op_t;

  op_t directed[$];
  int  order[$];

  initial begin
    // Reset state.
    #12;
    check("rst in_ready", in_ready, 1'b1);
    check("rst out_valid", out_valid, 1'b0);
    check("rst quotient", quotient, '0);
    check("rst remainder", remainder, '0);
    check("rst div_by_zero", div_by_zero, 1'b0);
    check("rst overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corners: sign combinations, overflow, most negative dividend,
    // divide by zero.
    directed.push_back('{8'd100, 4'd7});
    directed.push_back('{-8'sd100, 4'd7});
    directed.push_back('{8'd100, -4'sd7});
    directed.push_back('{-8'sd100, -4'sd8});
    directed.push_back('{8'h80, 4'hF});
    directed.push_back('{8'h80, 4'd1});
    directed.push_back('{8'd77, 4'd0});
    directed.push_back('{8'h80, 4'd0});
    directed.push_back('{8'd127, 4'h8});
    foreach (directed[i]) run_op(directed[i].a, directed[i].b, 0, $sformatf("dir%0d", i));

    // Backpressure: result held for five cycles.
    run_op(8'd100, 4'd7, 5, "bp");

    // Reset during CALC abandons the operation.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 8'd99;
    divisor  = 4'd4;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst in_ready", in_ready, 1'b1);
    check("midrst out_valid", out_valid, 1'b0);
    check("midrst quotient", quotient, '0);
    check("midrst remainder", remainder, '0);
    check("midrst div_by_zero", div_by_zero, 1'b0);
    check("midrst overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst no_result", out_valid, 1'b0);
    run_op(8'd50, 4'd5, 0, "post_rst");

    // Full operand sweep in shuffled order with random backpressure.
    for (int i = 0; i < 256 * 16; i++) order.push_back(i);
    order.shuffle();
    foreach (order[i]) begin
      logic [DW-1:0] a;
      logic [VW-1:0] b;
      a = order[i][11:4];
      b = order[i][3:0];
      run_op(a, b, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, "sweep");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
